sm4_core_arbiter: RTL and testbench

- Shares one SM4 encrypt/decrypt core between two requesters (req0, req1) with round-robin arbitration.
- Sequences the core for each request:
  - latches the 128-bit block and the direction;
  - issues a single-cycle start;
  - waits for the core's done pulse;
  - returns the result over a valid/ready response channel.
- Guards decrypt requests against an unexpanded key and times out a hung core.

---
 rtl/sm4_core_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_sm4_core_arbiter.sv | 553 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm4_core_arbiter.sv
// sm4_core_arbiter
//   Shares one SM4 encrypt/decrypt core between two requesters using
//   round-robin arbitration. For each accepted request it latches the block
//   and direction, pulses core_enable for one cycle, waits for core_done
//   (guarded by a watchdog), then presents the result on a per-requester
//   valid/ready response channel.
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   reqN_valid/decrypt/data    request from requester N (N = 0, 1)
//   reqN_ready                 combinational accept strobe (IDLE, winner only)
//   respN_valid/error/data     response to requester N; error = core timeout
//   respN_ready                requester N consumes its response
//   core_enable                one-cycle start to the core
//   core_sel, core_data        direction (1 = decrypt) and block to the core
//   core_key_ready             round keys expanded; gates decrypt requests
//   core_done, core_result     core completion pulse and its result
//   busy                       controller not idle
//   grant_id                   requester currently being served
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an eligible request; winner sees reqN_ready
// START | one-cycle core_enable, watchdog cleared
// WAIT  | core running; watchdog counts until done or timeout
// RESP  | response held on grant_id channel until respN_ready

module sm4_core_arbiter #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         req0_valid,
    input  logic         req0_decrypt,
    input  logic [127:0] req0_data,
    output logic         req0_ready,
    output logic         resp0_valid,
    output logic         resp0_error,
    output logic [127:0] resp0_data,
    input  logic         resp0_ready,

    input  logic         req1_valid,
    input  logic         req1_decrypt,
    input  logic [127:0] req1_data,
    output logic         req1_ready,
    output logic         resp1_valid,
    output logic         resp1_error,
    output logic [127:0] resp1_data,
    input  logic         resp1_ready,

    output logic         core_enable,
    output logic         core_sel,
    output logic [127:0] core_data,
    input  logic         core_key_ready,
    input  logic         core_done,
    input  logic [127:0] core_result,

    output logic         busy,
    output logic         grant_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_served;
    logic [CNT_W-1:0] wdog;

    logic elig0;
    logic elig1;
    logic win1;
    logic any_elig;
    logic timeout_hit;
    logic resp_ack;

    // Encrypt never waits on key expansion; decrypt needs the round keys.
    assign elig0    = req0_valid && (!req0_decrypt || core_key_ready);
    assign elig1    = req1_valid && (!req1_decrypt || core_key_ready);
    assign any_elig = elig0 || elig1;
    // On a tie the requester that was not served last wins.
    assign win1     = elig1 && (!elig0 || !last_served);

    assign timeout_hit = (wdog == CNT_W'(TIMEOUT_CYCLES - 1));
    assign resp_ack    = grant_id ? resp1_ready : resp0_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_elig)                  state_nxt = START;
            START:                                  state_nxt = WAIT;
            WAIT:    if (core_done || timeout_hit)  state_nxt = RESP;
            RESP:    if (resp_ack)                  state_nxt = IDLE;
            default:                                state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        core_enable = 1'b0;
        busy        = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = elig0 && !win1;
                req1_ready = win1;
            end
            START: begin
                busy        = 1'b1;
                core_enable = 1'b1;
            end
            WAIT: begin
                busy = 1'b1;
            end
            RESP: begin
                busy        = 1'b1;
                resp0_valid = !grant_id;
                resp1_valid = grant_id;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Datapath: request latch, watchdog, response capture, arbitration history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_sel    <= 1'b0;
            core_data   <= '0;
            grant_id    <= 1'b0;
            last_served <= 1'b1;
            wdog        <= '0;
            resp0_data  <= '0;
            resp0_error <= 1'b0;
            resp1_data  <= '0;
            resp1_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        grant_id  <= win1;
                        core_data <= win1 ? req1_data    : req0_data;
                        core_sel  <= win1 ? req1_decrypt : req0_decrypt;
                    end
                end
                START: begin
                    wdog <= '0;
                end
                WAIT: begin
                    wdog <= wdog + CNT_W'(1);
                    // A done pulse on the timeout cycle still delivers the result.
                    if (core_done) begin
                        if (grant_id) begin
                            resp1_data  <= core_result;
                            resp1_error <= 1'b0;
                        end else begin
                            resp0_data  <= core_result;
                            resp0_error <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        if (grant_id) begin
                            resp1_data  <= '0;
                            resp1_error <= 1'b1;
                        end else begin
                            resp0_data  <= '0;
                            resp0_error <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (resp_ack) begin
                        last_served <= grant_id;
                    end
                end
                default: begin
                    wdog <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm4_core_arbiter.sv
`timescale 1ns/1ps
module tb_sm4_core_arbiter;

    localparam int TIMEOUT_CYCLES = 40;
    localparam int CNT_W          = 6;
    localparam int CORE_LAT       = 34;
    localparam int BUDGET         = 200;

    localparam logic [127:0] KEY_PT = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] SM4_CT = 128'h681edf34d206965e86b3e94f536e4246;
    localparam logic [127:0] MASK   = 128'h5a5a_a5a5_3c3c_c3c3_0f0f_f0f0_9696_6969;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0_valid = 1'b0, req0_decrypt = 1'b0, req0_ready;
    logic [127:0] req0_data = '0;
    logic         resp0_valid, resp0_error, resp0_ready = 1'b0;
    logic [127:0] resp0_data;
    logic         req1_valid = 1'b0, req1_decrypt = 1'b0, req1_ready;
    logic [127:0] req1_data = '0;
    logic         resp1_valid, resp1_error, resp1_ready = 1'b0;
    logic [127:0] resp1_data;
    logic         core_enable, core_sel, core_key_ready = 1'b1;
    logic [127:0] core_data, core_result;
    logic         core_done;
    logic         busy, grant_id;

    sm4_core_arbiter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_decrypt(req0_decrypt), .req0_data(req0_data),
        .req0_ready(req0_ready), .resp0_valid(resp0_valid), .resp0_error(resp0_error),
        .resp0_data(resp0_data), .resp0_ready(resp0_ready),
        .req1_valid(req1_valid), .req1_decrypt(req1_decrypt), .req1_data(req1_data),
        .req1_ready(req1_ready), .resp1_valid(resp1_valid), .resp1_error(resp1_error),
        .resp1_data(resp1_data), .resp1_ready(resp1_ready),
        .core_enable(core_enable), .core_sel(core_sel), .core_data(core_data),
        .core_key_ready(core_key_ready), .core_done(core_done), .core_result(core_result),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Stand-in for the SM4 core: the standard test vector maps exactly; any
    // other block goes through a simple invertible transform.
    function automatic logic [127:0] sm4_model(input logic [127:0] x, input logic dec);
        logic [127:0] t;
        if (!dec) begin
            if (x == KEY_PT) return SM4_CT;
            return {x[126:0], x[127]} ^ MASK;
        end
        if (x == SM4_CT) return KEY_PT;
        t = x ^ MASK;
        return {t[0], t[127:1]};
    endfunction

    typedef struct packed {
        logic         id;
        logic         err;
        logic [127:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   enables = 0, accepts = 0, double_en = 0;
    logic en_prev = 1'b0;
    bit   saw_resp1 = 1'b0;
    bit   hang = 1'b0;
    logic stray_done = 1'b0;

    logic         mock_done, mock_busy, mock_dec;
    logic [127:0] mock_result, mock_in;
    int           mock_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mock_done <= 1'b0; mock_busy <= 1'b0; mock_cnt <= 0;
            mock_result <= '0; mock_in <= '0; mock_dec <= 1'b0;
        end else begin
            mock_done <= 1'b0;
            if (core_enable) begin
                mock_busy <= 1'b1; mock_cnt <= 0;
                mock_in <= core_data; mock_dec <= core_sel;
            end else if (mock_busy) begin
                if (mock_cnt == CORE_LAT - 1) begin
                    mock_busy <= 1'b0;
                    if (!hang) begin
                        mock_done   <= 1'b1;
                        mock_result <= sm4_model(mock_in, mock_dec);
                    end
                end else begin
                    mock_cnt <= mock_cnt + 1;
                end
            end
        end
    end

    assign core_done   = mock_done | stray_done;
    assign core_result = mock_result;

    function automatic exp_t make_exp(input logic id, input logic [127:0] d, input logic dec);
        exp_t e;
        e.id   = id;
        e.err  = hang;
        e.data = hang ? '0 : sm4_model(d, dec);
        return e;
    endfunction

    // Monitor: scoreboard pushes on every observed accept, plus start-pulse accounting.
    always @(negedge clk) begin
        if (reset) begin
            en_prev = 1'b0;
        end else begin
            if (req0_valid && req0_ready) begin
                sb_q.push_back(make_exp(1'b0, req0_data, req0_decrypt));
                accepts++;
            end
            if (req1_valid && req1_ready) begin
                sb_q.push_back(make_exp(1'b1, req1_data, req1_decrypt));
                accepts++;
            end
            if (core_enable) begin
                enables++;
                if (en_prev) double_en++;
            end
            en_prev = core_enable;
            if (resp1_valid) saw_resp1 = 1'b1;
        end
    end

    task automatic wait_accept(input bit n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if ((n ? req1_ready : req0_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_resp(input bit n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if ((n ? resp1_valid : resp0_valid) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic handshake(input bit n);
        if (n) resp1_ready = 1'b1; else resp0_ready = 1'b1;
        @(posedge clk); #1;
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({core_enable, core_sel, busy, grant_id, resp0_valid, resp0_error,
             resp1_valid, resp1_error} !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b, expected 00000000",
                     {core_enable, core_sel, busy, grant_id, resp0_valid, resp0_error,
                      resp1_valid, resp1_error});
        end
        n_checks++;
        if (core_data !== '0) begin
            n_errors++;
            $display("FAIL reset_core_data: got %h, expected 0", core_data);
        end
        n_checks++;
        if (resp0_data !== '0 || resp1_data !== '0) begin
            n_errors++;
            $display("FAIL reset_resp_data: got %h / %h, expected 0", resp0_data, resp1_data);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_encrypt();
        bit ok;
        int en0;
        exp_t e;
        saw_resp1 = 1'b0;
        en0 = enables;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_decrypt = 1'b0; req0_data = KEY_PT;
        wait_accept(1'b0, ok);
        req0_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (!ok || core_enable !== 1'b1 || core_sel !== 1'b0 || core_data !== KEY_PT ||
            grant_id !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL enc_start: ok=%0d en=%b sel=%b data=%h grant=%b busy=%b, expected 1 1 0 %h 0 1",
                     ok, core_enable, core_sel, core_data, grant_id, busy, KEY_PT);
        end
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (core_done) begin ok = 1'b1; break; end
        end
        @(negedge clk);
        n_checks++;
        if (!ok || resp0_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL enc_latency: done_seen=%0d resp0_valid=%b, expected 1 1", ok, resp0_valid);
        end
        n_checks++;
        if (resp0_data !== SM4_CT || resp0_error !== 1'b0) begin
            n_errors++;
            $display("FAIL enc_vector: got %h err=%b, expected %h err=0", resp0_data, resp0_error, SM4_CT);
        end
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL enc_sb: got empty scoreboard, expected one entry");
        end else begin
            e = sb_q.pop_front();
            if (e.id !== 1'b0 || resp0_data !== e.data || resp0_error !== e.err) begin
                n_errors++;
                $display("FAIL enc_sb: got %h err=%b, expected id0 %h err=%b",
                         resp0_data, resp0_error, e.data, e.err);
            end
        end
        handshake(1'b0);
        @(negedge clk);
        n_checks++;
        if (resp0_valid !== 1'b0 || busy !== 1'b0 || (enables - en0) != 1 || saw_resp1) begin
            n_errors++;
            $display("FAIL enc_after: valid=%b busy=%b starts=%0d resp1_seen=%0d, expected 0 0 1 0",
                     resp0_valid, busy, enables - en0, saw_resp1);
        end
    endtask

    task automatic test_decrypt_gating();
        bit ok;
        int early;
        exp_t e;
        early = 0;
        @(posedge clk); #1;
        core_key_ready = 1'b0;
        req1_valid = 1'b1; req1_decrypt = 1'b1; req1_data = SM4_CT;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req1_ready !== 1'b0 || busy !== 1'b0) early++;
        end
        n_checks++;
        if (early != 0) begin
            n_errors++;
            $display("FAIL dec_gated: got %0d cycles with ready/busy, expected 0", early);
        end
        @(posedge clk); #1;
        core_key_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req1_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL dec_first_ready: got %b, expected 1", req1_ready);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_resp(1'b1, ok);
        n_checks++;
        if (!ok || resp1_data !== KEY_PT || resp1_error !== 1'b0) begin
            n_errors++;
            $display("FAIL dec_result: ok=%0d got %h err=%b, expected %h err=0",
                     ok, resp1_data, resp1_error, KEY_PT);
        end
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL dec_sb: got empty scoreboard, expected one entry");
        end else begin
            e = sb_q.pop_front();
            if (e.id !== 1'b1 || resp1_data !== e.data || resp1_error !== e.err) begin
                n_errors++;
                $display("FAIL dec_sb: got %h, expected id1 %h", resp1_data, e.data);
            end
        end
        handshake(1'b1);
    endtask

    task automatic test_round_robin();
        bit ok;
        logic got;
        exp_t e;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_decrypt = 1'b0; req0_data = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        req1_valid = 1'b1; req1_decrypt = 1'b1; req1_data = 128'hdead_beef_cafe_f00d_0bad_c0de_1234_5678;
        for (int r = 0; r < 4; r++) begin
            ok = 1'b0;
            got = 1'b0;
            for (int i = 0; i < BUDGET; i++) begin
                @(negedge clk);
                if (resp0_valid === 1'b1 || resp1_valid === 1'b1) begin
                    ok = 1'b1;
                    got = resp1_valid;
                    break;
                end
            end
            n_checks++;
            if (!ok || got !== r[0]) begin
                n_errors++;
                $display("FAIL rr_order[%0d]: ok=%0d got id %b, expected id %0d", r, ok, got, r % 2);
            end
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL rr_data[%0d]: got empty scoreboard, expected entry", r);
            end else begin
                e = sb_q.pop_front();
                if (e.id !== got || (got ? resp1_data : resp0_data) !== e.data ||
                    (got ? resp1_error : resp0_error) !== 1'b0) begin
                    n_errors++;
                    $display("FAIL rr_data[%0d]: got id %b %h, expected id %b %h", r, got,
                             got ? resp1_data : resp0_data, e.id, e.data);
                end
            end
            if (got) req1_data = req1_data + 128'h0101; else req0_data = req0_data ^ 128'hff00;
            if (r == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            handshake(got);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int cnt;
        exp_t e;
        hang = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_decrypt = 1'b0; req0_data = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        wait_accept(1'b0, ok);
        req0_valid = 1'b0;
        @(negedge clk);
        cnt = 0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            cnt++;
            if (resp0_valid === 1'b1) break;
        end
        // cnt counts from the START sample, so the first WAIT sample is cnt=1.
        n_checks++;
        if (!ok || cnt != TIMEOUT_CYCLES + 1) begin
            n_errors++;
            $display("FAIL to_timing: got %0d cycles after WAIT entry, expected %0d", cnt - 1, TIMEOUT_CYCLES);
        end
        n_checks++;
        if (resp0_valid !== 1'b1 || resp0_error !== 1'b1 || resp0_data !== '0) begin
            n_errors++;
            $display("FAIL to_resp: got valid=%b err=%b data=%h, expected 1 1 0",
                     resp0_valid, resp0_error, resp0_data);
        end
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL to_sb: got empty scoreboard, expected entry");
        end else begin
            e = sb_q.pop_front();
            if (e.id !== 1'b0 || e.err !== resp0_error || e.data !== resp0_data) begin
                n_errors++;
                $display("FAIL to_sb: got err=%b %h, expected err=%b %h", resp0_error, resp0_data, e.err, e.data);
            end
        end
        handshake(1'b0);
        hang = 1'b0;
    endtask

    task automatic test_stray_done();
        logic [127:0] d0;
        repeat (2) @(posedge clk);
        #1;
        d0 = resp0_data;
        stray_done = 1'b1;
        @(posedge clk); #1;
        stray_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || resp0_valid !== 1'b0 || resp1_valid !== 1'b0 || resp0_data !== d0) begin
            n_errors++;
            $display("FAIL stray_done: got busy=%b v0=%b v1=%b data=%h, expected 0 0 0 %h",
                     busy, resp0_valid, resp1_valid, resp0_data, d0);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad;
        logic [127:0] d0;
        exp_t e;
        bad = 0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_decrypt = 1'b0; req0_data = 128'h00112233445566778899aabbccddeeff;
        wait_accept(1'b0, ok);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_decrypt = 1'b0; req1_data = 128'hfedcba98765432100123456789abcdef;
        wait_resp(1'b0, ok);
        d0 = resp0_data;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL bp_data: got empty scoreboard, expected entry");
        end else begin
            e = sb_q.pop_front();
            if (!ok || e.id !== 1'b0 || resp0_data !== e.data || resp0_error !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_data: ok=%0d got %h, expected %h", ok, resp0_data, e.data);
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp0_valid !== 1'b1 || resp0_data !== d0 || req1_ready !== 1'b0 || resp1_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL bp_hold: got %0d unstable cycles, expected 0", bad);
        end
        handshake(1'b0);
        @(negedge clk);
        n_checks++;
        if (req1_ready !== 1'b1 || resp0_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_next_accept: got ready1=%b valid0=%b, expected 1 0", req1_ready, resp0_valid);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_resp(1'b1, ok);
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL bp_req1: got empty scoreboard, expected entry");
        end else begin
            e = sb_q.pop_front();
            if (!ok || e.id !== 1'b1 || resp1_data !== e.data) begin
                n_errors++;
                $display("FAIL bp_req1: ok=%0d got %h, expected %h", ok, resp1_data, e.data);
            end
        end
        handshake(1'b1);
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        exp_t e;
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_decrypt = 1'b0; req1_data = 128'h13579bdf2468ace013579bdf2468ace0;
        wait_accept(1'b1, ok);
        req1_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (!ok || busy !== 1'b1 || grant_id !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_pre: ok=%0d busy=%b grant=%b, expected 1 1 1", ok, busy, grant_id);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({core_enable, core_sel, busy, grant_id, resp0_valid, resp0_error, resp1_valid, resp1_error} !== 8'h00 ||
            core_data !== '0 || resp0_data !== '0 || resp1_data !== '0) begin
            n_errors++;
            $display("FAIL rst_mid: got ctrl=%b core_data=%h, expected all 0",
                     {core_enable, core_sel, busy, grant_id, resp0_valid, resp0_error, resp1_valid, resp1_error},
                     core_data);
        end
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_decrypt = 1'b0; req0_data = 128'haaaa_0000_bbbb_1111_cccc_2222_dddd_3333;
        req1_valid = 1'b1; req1_decrypt = 1'b0; req1_data = 128'h4444_eeee_5555_ffff_6666_0000_7777_1111;
        @(negedge clk);
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_priority: got ready0=%b ready1=%b, expected 1 0", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_resp(1'b0, ok);
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL rst_req0: got empty scoreboard, expected entry");
        end else begin
            e = sb_q.pop_front();
            if (!ok || e.id !== 1'b0 || resp0_data !== e.data || resp0_error !== 1'b0) begin
                n_errors++;
                $display("FAIL rst_req0: ok=%0d got %h, expected %h", ok, resp0_data, e.data);
            end
        end
        handshake(1'b0);
        wait_accept(1'b1, ok);
        req1_valid = 1'b0;
        wait_resp(1'b1, ok);
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL rst_req1: got empty scoreboard, expected entry");
        end else begin
            e = sb_q.pop_front();
            if (!ok || e.id !== 1'b1 || resp1_data !== e.data) begin
                n_errors++;
                $display("FAIL rst_req1: ok=%0d got %h, expected %h", ok, resp1_data, e.data);
            end
        end
        handshake(1'b1);
    endtask

    initial begin
        test_reset();
        test_single_encrypt();
        test_decrypt_gating();
        test_round_robin();
        test_timeout();
        test_stray_done();
        test_backpressure();
        test_reset_mid_wait();
        repeat (3) @(negedge clk);
        n_checks++;
        if (enables != accepts || double_en != 0) begin
            n_errors++;
            $display("FAIL start_pulses: got %0d starts (%0d wide) for %0d accepts, expected equal and 0 wide",
                     enables, double_en, accepts);
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_leftover: got %0d pending entries, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500us;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "global timeout");
    end

endmodule
